apb_image_loader: RTL
=====================

Name: apb_image_loader

Overview:
- APB initiator that drives the classifier's APB register-file slave.
- Accepts a start pulse and a stream of packed pixel words.
- Writes the words to data registers DATA_BASE..DATA_BASE+NUM_WORDS-1, writes CTRL_ADDR=1 to launch inference, then reads RESULT_ADDR; the slave stalls via pReady until done.
- Returns the read word as the classification result; sits between the host/DMA side and the APB bus.

Parameters:
- AMBA_WORD, 32, APB data width.
- AMBA_ADDR_DEPTH, 8, APB address width.
- NUM_WORDS, 2, pixel words per image (8 px x 8 b / 32).
- DATA_BASE, 1, address of first pixel word.
- CTRL_ADDR, 0, control register; bit0=start.
- RESULT_ADDR, 0, register read for the result.
- TIMEOUT_CYCLES, 255, max ACCESS wait cycles (optional feature only).

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one image sequence; ignored while busy.
- busy  out  1  high from start acceptance until sequence end.
- din_valid  in  1  pixel word valid.
- din_ready  out  1  loader accepts pixel word.
- din_data  in  AMBA_WORD  packed pixel word.
- pSelect  out  1  APB select.
- pEnable  out  1  APB enable.
- pWrite  out  1  APB direction; 1=write.
- pAddr  out  AMBA_ADDR_DEPTH  APB address.
- pWData  out  AMBA_WORD  APB write data.
- pReady  in  1  slave ready / wait-state extender.
- pRData  in  AMBA_WORD  slave read data.
- result_valid  out  1  one-cycle pulse, result updated.
- result  out  AMBA_WORD  last RESULT_ADDR read; held until next start.
- error  out  1  transfer timeout, sticky until next start (0 without feature).

Behaviour:
- Reset (async, Rst=1): all outputs 0; state IDLE; word counter 0; holding buffer empty; timeout counter 0.
- Reset mid-transfer aborts immediately; pSelect/pEnable drop asynchronously.
- Sequencer states: IDLE, LOAD, CTRL, READ, DONE.
- APB phase engine states: BUS_IDLE, SETUP, ACCESS.
  - SETUP: exactly one cycle, pSelect=1, pEnable=0.
  - ACCESS: pSelect=1, pEnable=1; held while pReady=0.
  - Transfer completes at the posedge where ACCESS and pReady=1.
  - pAddr, pWrite and pWData are registered in SETUP and stable through ACCESS.
  - pAddr and pWData are 0 in BUS_IDLE.
- IDLE:
  - start=1 at posedge -> LOAD, busy=1, counter=0, error cleared, result cleared.
  - start while busy is ignored.
- LOAD:
  - din_ready = (state==LOAD) & !buf_full & (accepted<NUM_WORDS); combinational.
  - A din_valid&din_ready handshake fills a 1-word buffer.
  - Buffer full and engine BUS_IDLE or completing -> SETUP, write pAddr=DATA_BASE+counter, pWData=buffer; the buffer frees at SETUP.
  - Back-to-back: if the buffer is full when ACCESS completes and words remain, go directly ACCESS->SETUP (pSelect stays 1). Otherwise go to BUS_IDLE.
  - After the NUM_WORDS-th completion -> CTRL.
- CTRL: single write, pAddr=CTRL_ADDR, pWData=1; on completion -> READ.
- READ:
  - Single read, pAddr=RESULT_ADDR, pWrite=0.
  - On completion: result<=pRData, result_valid=1 for one cycle -> DONE.
- DONE: busy=0 next cycle -> IDLE.
- Zero-wait latency, data ready each cycle, NUM_WORDS=2:
  - start at edge 0; din accepted edges 1,2.
  - Writes complete edges 3,5 (SETUP/ACCESS pairs: cycles 2-3, 4-5).
  - CTRL completes edge 7; READ completes edge 9 with result_valid high cycle 10; busy low cycle 11.
- Unused and upper pWData bits are 0. The word counter is clog2(NUM_WORDS+1) wide and does not wrap.
- din_valid while not in LOAD is ignored; the data is not consumed.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - Counter increments each ACCESS cycle with pReady=0; it resets at each SETUP.
  - On reaching TIMEOUT_CYCLES the next cycle drives pSelect=pEnable=0, sets error=1, busy=0 and returns to IDLE.
  - result_valid is not pulsed on timeout.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; error tied 0.

Decomposition:
- Shared package apb_pkg holds:
  - APB phase encodings (BUS_IDLE, SETUP, ACCESS).
  - Sequencer state encodings.
  - Default widths (AMBA_WORD, AMBA_ADDR_DEPTH).
  - Register map constants (CTRL_ADDR, DATA_BASE, RESULT_ADDR).
- One natural sub-module: apb_master_phy. It is a single-transfer engine with req/addr/wdata/write in, done/rdata out, and owns SETUP/ACCESS timing and the optional timeout.
- apb_image_loader holds the sequencer, buffer and counter.

Test Plan:
- Zero-wait slave, data words 0xA1B2C3D4, 0x11223344, continuous din_valid -> writes to addr 1,2, then CTRL write 0x1 to addr 0, then read addr 0. Timing exactly as the latency example; busy low at cycle 11.
- Slave inserts 3 wait states on the READ, pRData=0x1 -> ACCESS held 4 cycles with address/control stable; result=0x00000001 with a single result_valid pulse.
- din_valid gapped (word 2 arrives 5 cycles late) -> pSelect=0 between transfers; no SETUP without buffered data; addresses still 1,2.
- Assert Rst during the second pixel ACCESS -> pSelect, pEnable, busy, din_ready go 0 immediately. A following start replays from addr 1.
- start pulsed again while busy -> ignored; exactly one sequence (4 APB transfers) observed.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pReady stuck 0 on CTRL write -> bus released after 4 wait cycles; error=1, busy=0, no result_valid; next start clears error.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB loader definitions: phase/sequencer encodings, default widths and register map.
package apb_pkg;
    localparam int DEF_AMBA_WORD       = 32;
    localparam int DEF_AMBA_ADDR_DEPTH = 8;
    localparam int DEF_NUM_WORDS       = 2;
    localparam int DEF_DATA_BASE       = 1;
    localparam int DEF_CTRL_ADDR       = 0;
    localparam int DEF_RESULT_ADDR     = 0;
    localparam int DEF_TIMEOUT_CYCLES  = 255;

    typedef enum logic [1:0] {BUS_IDLE, SETUP, ACCESS} apb_phase_e;
    typedef enum logic [2:0] {IDLE, LOAD, CTRL, READ, DONE} seq_state_e;
endpackage

// File: rtl/apb_master_phy.sv
// Single-transfer APB engine: owns SETUP/ACCESS timing; APB_TIMEOUT_EN adds an ACCESS wait limit.
module apb_master_phy
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = DEF_AMBA_WORD,
    parameter int AMBA_ADDR_DEPTH = DEF_AMBA_ADDR_DEPTH,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       req,
    input  logic                       req_write,
    input  logic [AMBA_ADDR_DEPTH-1:0] req_addr,
    input  logic [AMBA_WORD-1:0]       req_wdata,
    output logic                       ready,
    output logic                       done,
    output logic                       timeout,
    output logic [AMBA_WORD-1:0]       rdata,
    output logic                       pSelect,
    output logic                       pEnable,
    output logic                       pWrite,
    output logic [AMBA_ADDR_DEPTH-1:0] pAddr,
    output logic [AMBA_WORD-1:0]       pWData,
    input  logic                       pReady,
    input  logic [AMBA_WORD-1:0]       pRData
);
    apb_phase_e                 phase_q, phase_d;
    logic [AMBA_ADDR_DEPTH-1:0] addr_q, addr_d;
    logic [AMBA_WORD-1:0]       wdata_q, wdata_d;
    logic                       write_q, write_d;
`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
`endif

    always_comb begin
        phase_d = phase_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        done    = (phase_q == ACCESS) && pReady;
        ready   = (phase_q == BUS_IDLE) || done;
        timeout = 1'b0;
        case (phase_q)
            SETUP:   phase_d = ACCESS;
            ACCESS:  if (pReady) phase_d = BUS_IDLE;
            default: ;
        endcase
`ifdef APB_TIMEOUT_EN
        tcnt_d = tcnt_q;
        if (phase_q == ACCESS && !pReady) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_d == TW'(TIMEOUT_CYCLES)) begin
                timeout = 1'b1;
                phase_d = BUS_IDLE;
            end
        end
`endif
        // A completing ACCESS may hand straight over to the next SETUP.
        if (req && ready) begin
            phase_d = SETUP;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            write_d = req_write;
`ifdef APB_TIMEOUT_EN
            tcnt_d  = '0;
`endif
        end else if (phase_d == BUS_IDLE) begin
            addr_d  = '0;
            wdata_d = '0;
            write_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            phase_q <= BUS_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    assign pSelect = (phase_q != BUS_IDLE);
    assign pEnable = (phase_q == ACCESS);
    assign pWrite  = write_q;
    assign pAddr   = addr_q;
    assign pWData  = wdata_q;
    assign rdata   = pRData;
endmodule

// File: rtl/apb_image_loader.sv
// Image loader: streams pixel words to the classifier over APB, launches it, reads the result.
// Optional ACCESS timeout (sticky error) enabled with APB_TIMEOUT_EN.
module apb_image_loader
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = DEF_AMBA_WORD,
    parameter int AMBA_ADDR_DEPTH = DEF_AMBA_ADDR_DEPTH,
    parameter int NUM_WORDS       = DEF_NUM_WORDS,
    parameter int DATA_BASE       = DEF_DATA_BASE,
    parameter int CTRL_ADDR       = DEF_CTRL_ADDR,
    parameter int RESULT_ADDR     = DEF_RESULT_ADDR,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       start,
    output logic                       busy,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [AMBA_WORD-1:0]       din_data,
    output logic                       pSelect,
    output logic                       pEnable,
    output logic                       pWrite,
    output logic [AMBA_ADDR_DEPTH-1:0] pAddr,
    output logic [AMBA_WORD-1:0]       pWData,
    input  logic                       pReady,
    input  logic [AMBA_WORD-1:0]       pRData,
    output logic                       result_valid,
    output logic [AMBA_WORD-1:0]       result,
    output logic                       error
);
    localparam int CW = $clog2(NUM_WORDS + 1);

    seq_state_e           state_q, state_d;
    logic [CW-1:0]        acc_q, acc_d, wr_q, wr_d;
    logic                 buf_full_q, buf_full_d;
    logic [AMBA_WORD-1:0] buf_q, buf_d, result_q, result_d;
    logic                 rv_q, rv_d, error_q, error_d;

    logic                       req, req_write, hs;
    logic [AMBA_ADDR_DEPTH-1:0] req_addr;
    logic [AMBA_WORD-1:0]       req_wdata, phy_rdata;
    logic                       phy_ready, phy_done, phy_timeout;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        wr_d       = wr_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        result_d   = result_q;
        error_d    = error_q;
        rv_d       = 1'b0;
        req        = 1'b0;
        req_write  = 1'b1;
        req_addr   = '0;
        req_wdata  = '0;
        din_ready  = (state_q == LOAD) && !buf_full_q && (acc_q < CW'(NUM_WORDS));
        hs         = din_valid && din_ready;
        case (state_q)
            IDLE: if (start) begin
                state_d    = LOAD;
                acc_d      = '0;
                wr_d       = '0;
                buf_full_d = 1'b0;
                error_d    = 1'b0;
                result_d   = '0;
            end
            LOAD: begin
                if (hs) acc_d = acc_q + CW'(1);
                // An idle engine takes the incoming word directly; otherwise it waits in the buffer.
                if ((buf_full_q || hs) && phy_ready) begin
                    req        = 1'b1;
                    req_addr   = AMBA_ADDR_DEPTH'(DATA_BASE) + AMBA_ADDR_DEPTH'(wr_q);
                    req_wdata  = buf_full_q ? buf_q : din_data;
                    buf_full_d = 1'b0;
                    wr_d       = wr_q + CW'(1);
                end else if (hs) begin
                    buf_full_d = 1'b1;
                    buf_d      = din_data;
                end
                if (phy_done && wr_q == CW'(NUM_WORDS)) begin
                    req       = 1'b1;
                    req_addr  = AMBA_ADDR_DEPTH'(CTRL_ADDR);
                    req_wdata = AMBA_WORD'(1);
                    state_d   = CTRL;
                end
            end
            CTRL: if (phy_done) begin
                req       = 1'b1;
                req_write = 1'b0;
                req_addr  = AMBA_ADDR_DEPTH'(RESULT_ADDR);
                state_d   = READ;
            end
            READ: if (phy_done) begin
                rv_d     = 1'b1;
                result_d = phy_rdata;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (phy_timeout) begin
            state_d    = IDLE;
            error_d    = 1'b1;
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            wr_q       <= '0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            result_q   <= '0;
            rv_q       <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            wr_q       <= wr_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            error_q    <= error_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = rv_q;
    assign error        = error_q;

    apb_master_phy #(
        .AMBA_WORD      (AMBA_WORD),
        .AMBA_ADDR_DEPTH(AMBA_ADDR_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phy (
        .Clk      (Clk),
        .Rst      (Rst),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .ready    (phy_ready),
        .done     (phy_done),
        .timeout  (phy_timeout),
        .rdata    (phy_rdata),
        .pSelect  (pSelect),
        .pEnable  (pEnable),
        .pWrite   (pWrite),
        .pAddr    (pAddr),
        .pWData   (pWData),
        .pReady   (pReady),
        .pRData   (pRData)
    );
endmodule
